// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// to_gray is used when SWEEP_GRAY_ORDER_EN is defined.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StFinish
  } state_e;

  localparam int unsigned N_IN_DEF   = 4;
  localparam int unsigned SETTLE_DEF = 4;

  function automatic logic [31:0] to_gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sweep_step_gen.sv
// Step/hold counters for the sweeper; emits the applied code, capture strobe and last-step flag.
// Define SWEEP_GRAY_ORDER_EN to apply codes in Gray order instead of binary order.
module sweep_step_gen
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            run,
  output logic [N_IN-1:0] code,
  output logic            capture,
  output logic            last
);

  localparam int unsigned HoldW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  StepMax = '1;

  logic [N_IN-1:0]  step_q;
  logic [N_IN-1:0]  step_nxt;
  logic [N_IN-1:0]  code_nxt;
  logic [HoldW-1:0] hold_q;

  assign capture  = run && (hold_q == HoldMax);
  assign last     = (step_q == StepMax);
  assign step_nxt = step_q + N_IN'(1);

`ifdef SWEEP_GRAY_ORDER_EN
  assign code_nxt = N_IN'(to_gray(32'(step_nxt)));
`else
  assign code_nxt = step_nxt;
`endif

  // Code 0 is the first vector in both orders, so clear loads zero directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      hold_q <= '0;
      code   <= '0;
    end else if (clear) begin
      step_q <= '0;
      hold_q <= '0;
      code   <= '0;
    end else if (run) begin
      if (capture) begin
        hold_q <= '0;
        if (!last) begin
          step_q <= step_nxt;
          code   <= code_nxt;
        end
      end else begin
        hold_q <= hold_q + HoldW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a combinational function through all input codes and checks the measured truth table.
// Define SWEEP_GRAY_ORDER_EN for Gray-ordered application (results are order-independent).
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt
);

  localparam int unsigned Entries = 2 ** N_IN;

  state_e             state_q;
  logic [Entries-1:0] exp_q;
  logic               clear;
  logic               run;
  logic               capture;
  logic               last;
  logic               miss;
  logic [N_IN:0]      mism_nxt;

  assign clear    = (state_q == StIdle) && start;
  assign run      = (state_q == StApply) && !abort;
  assign miss     = (dut_out != exp_q[dut_in]);
  assign mism_nxt = mismatch_cnt + (N_IN + 1)'(miss);

  sweep_step_gen #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_step_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .run     (run),
    .code    (dut_in),
    .capture (capture),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      exp_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            exp_q        <= expected;
            table_out    <= '0;
            mismatch_cnt <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            state_q      <= StApply;
          end
        end
        StApply: begin
          if (abort) begin
            busy    <= 1'b0;
            pass    <= 1'b0;
            state_q <= StIdle;
          end else if (capture) begin
            table_out[dut_in] <= dut_out;
            mismatch_cnt      <= mism_nxt;
            if (last) begin
              // pass must include this final capture, hence mism_nxt
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (mism_nxt == '0);
              state_q <= StFinish;
            end
          end
        end
        StFinish: begin
          if (abort) pass <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: S=4 and S=1 instances driven by table-lookup functions.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;

  logic        start, abort;
  logic [15:0] expected;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic        busy, done, pass;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;
  logic [15:0] fn_a;

  logic        start_b, abort_b;
  logic [15:0] expected_b;
  logic [3:0]  dut_in_b;
  logic        dut_out_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] table_out_b;
  logic [4:0]  mismatch_cnt_b;
  logic [15:0] fn_b;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  mism;
  } exp_t;

  exp_t sb[$];

  assign dut_out   = fn_a[dut_in];
  assign dut_out_b = fn_b[dut_in_b];

  truth_table_sweeper #(
    .N_IN          (4),
    .SETTLE_CYCLES (4)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .table_out    (table_out),
    .mismatch_cnt (mismatch_cnt)
  );

  truth_table_sweeper #(
    .N_IN          (4),
    .SETTLE_CYCLES (1)
  ) u_dut_s1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_b),
    .abort        (abort_b),
    .expected     (expected_b),
    .dut_in       (dut_in_b),
    .dut_out      (dut_out_b),
    .busy         (busy_b),
    .done         (done_b),
    .pass         (pass_b),
    .table_out    (table_out_b),
    .mismatch_cnt (mismatch_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] code_of(input int s);
`ifdef SWEEP_GRAY_ORDER_EN
    return 4'(s ^ (s >> 1));
`else
    return 4'(s);
`endif
  endfunction

  task automatic push_exp(input logic [15:0] fn, input logic [15:0] ex);
    exp_t e;
    e.tbl  = fn;
    e.mism = 5'($countones(fn ^ ex));
    e.pass = (e.mism == 5'd0);
    sb.push_back(e);
  endtask

  // Full S=4 sweep; with_abort asserts abort together with start (start must win).
  task automatic run_sweep(input logic [15:0] fn, input logic [15:0] ex, input logic with_abort);
    exp_t e;
    logic early;
    logic [3:0] prev;
    fn_a = fn;
    push_exp(fn, ex);
    @(negedge clk);
    expected = ex;
    start    = 1'b1;
    abort    = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("busy_on", busy, 1);
    check_eq("code_0", dut_in, code_of(0));
    early = 1'b0;
    prev  = dut_in;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (k < 64) begin
        if (done) early = 1'b1;
        if (k % 4 == 0) begin
          check_eq("code_step", dut_in, code_of(k / 4));
`ifdef SWEEP_GRAY_ORDER_EN
          check_eq("gray_one_bit", $countones(dut_in ^ prev), 1);
`endif
          prev = dut_in;
        end
      end
    end
    check_eq("done_at_65", done, 1);
    check_eq("busy_off", busy, 0);
    check_eq("no_early_done", early, 0);
    e = sb.pop_front();
    check_eq("table_out", table_out, e.tbl);
    check_eq("pass", pass, e.pass);
    check_eq("mismatch_cnt", mismatch_cnt, e.mism);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("pass_held", pass, e.pass);
  endtask

  initial begin
    exp_t e;
    logic seen_done;

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    expected   = '0;
    fn_a       = '0;
    start_b    = 1'b0;
    abort_b    = 1'b0;
    expected_b = '0;
    fn_b       = 16'h5555;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_dut_in", dut_in, 0);
    check_eq("rst_table", table_out, 0);
    check_eq("rst_mism", mismatch_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Matching table, then one deliberate expected-table error.
    run_sweep(16'h6300, 16'h6300, 1'b0);
    run_sweep(16'h6300, 16'h6301, 1'b0);

    // S=1 inverting function: one capture per cycle, done 17 cycles after start.
    push_exp(fn_b, 16'h5555);
    @(negedge clk);
    expected_b = 16'h5555;
    start_b    = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    check_eq("s1_code_0", dut_in_b, code_of(0));
    seen_done = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k < 16) begin
        check_eq("s1_code_step", dut_in_b, code_of(k));
        if (done_b) seen_done = 1'b1;
      end
    end
    check_eq("s1_no_early_done", seen_done, 0);
    check_eq("s1_done_at_17", done_b, 1);
    e = sb.pop_front();
    check_eq("s1_table", table_out_b, e.tbl);
    check_eq("s1_pass", pass_b, e.pass);
    check_eq("s1_mism", mismatch_cnt_b, e.mism);

    // Abort at cycle 20: codes 0..3 captured, all four mismatch against 16'h630F.
    fn_a = 16'h6300;
    @(negedge clk);
    expected = 16'h630F;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_pass", pass, 0);
    check_eq("abort_mism", mismatch_cnt, 4);
    check_eq("abort_table", table_out, 16'h0000);
    // abort held in IDLE must have no effect
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    abort = 1'b0;
    check_eq("abort_idle_quiet", seen_done, 0);
    check_eq("abort_idle_mism", mismatch_cnt, 4);

    // Restart with abort asserted alongside start.
    run_sweep(16'h6300, 16'h6300, 1'b1);

    // Asynchronous reset mid-sweep at step 7.
    fn_a = 16'h5555;
    @(negedge clk);
    expected = 16'h5555;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("pre_rst_table0", table_out[0], 1);
    check_eq("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_dut_in", dut_in, 0);
    check_eq("arst_table", table_out, 0);
    check_eq("arst_mism", mismatch_cnt, 0);
    check_eq("arst_pass", pass, 0);
    check_eq("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(16'h6300, 16'h6300, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
